// File: rtl/frame_pkg.sv
// Shared types and framing constants for the 10-bit frame serializer.
package frame_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int   FRAME_W   = 10;
  localparam int   START_POS = 0;
  localparam int   STOP_POS  = 9;
  localparam logic START_VAL = 1'b0;
  localparam logic STOP_VAL  = 1'b1;

  function automatic logic frame_well_formed(input logic [FRAME_W-1:0] word);
    return (word[START_POS] == START_VAL) && (word[STOP_POS] == STOP_VAL);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period tick generator: one tick every CLKS_PER_BIT enabled cycles,
// count restarts from zero whenever enable is low.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (!enable || count == LAST) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/frame_serializer.sv
// Serializes pre-framed 10-bit words LSB first, CLKS_PER_BIT clocks per bit.
// Define FRAME_SERIALIZER_FRAME_CHECK_EN to reject words with bad start/stop bits.
module frame_serializer
  import frame_pkg::*;
#(
  parameter int   CLKS_PER_BIT = 16,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_word_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               tx_serial,
  output logic               tx_busy,
  output logic               framing_err,
  output logic [15:0]        words_sent,
  output state_t             fsm_state
);

  // Handshake: a word transfers on any posedge where frame_valid && frame_ready;
  // the source holds frame_word_in stable while frame_valid is high and ready is low,
  // and frame_ready depends only on the registered state.

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] shift_reg, shift_nxt;
  logic [3:0]         bit_idx, bit_idx_nxt;
  logic [15:0]        sent_nxt;
  logic               word_ok;
  logic               tick;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (state == SHIFT),
    .tick   (tick)
  );

`ifdef FRAME_SERIALIZER_FRAME_CHECK_EN
  assign word_ok = frame_well_formed(frame_word_in);

  // Malformed words are consumed in IDLE and flagged for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_err <= 1'b0;
    end else begin
      framing_err <= (state == IDLE) && frame_valid && !word_ok;
    end
  end
`else
  assign word_ok     = 1'b1;
  assign framing_err = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_idx_nxt = bit_idx;
    sent_nxt    = words_sent;
    case (state)
      IDLE: begin
        if (frame_valid && word_ok) begin
          state_nxt   = SHIFT;
          shift_nxt   = frame_word_in;
          bit_idx_nxt = 4'd0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_idx == 4'(STOP_POS)) begin
            state_nxt   = IDLE;
            bit_idx_nxt = 4'd0;
            sent_nxt    = words_sent + 16'd1;
          end else begin
            shift_nxt   = shift_reg >> 1;
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= 4'd0;
      words_sent <= 16'd0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_idx    <= bit_idx_nxt;
      words_sent <= sent_nxt;
    end
  end

  assign frame_ready = (state == IDLE);
  assign tx_busy     = (state == SHIFT);
  assign tx_serial   = tx_busy ? shift_reg[0] : IDLE_LEVEL;
  assign fsm_state   = state;

endmodule
